// File: rtl/dispensador_cambio.sv
// dispensador_cambio: change dispenser FSM paying greedy 5/1-unit coins with an ack handshake.
// Segment outputs are the only combinational outputs; everything else is registered.
module dispensador_cambio (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] saldo,
  input  logic [3:0] precio,
  input  logic       iniciar,
  input  logic       cancelar,
  input  logic       ack_moneda,
  output logic       expulsar5,
  output logic       expulsar1,
  output logic       ocupado,
  output logic       listo,
  output logic       error_saldo,
  output logic [3:0] pendiente,
  output logic [6:0] segm1,
  output logic [6:0] segm2
);
  typedef enum logic [2:0] {INACTIVO, CARGA, PIDE5, PIDE1, ESPERA_ACK, FIN} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_pend, r_saldo, r_precio, w_pend, w_carga, w_unid;
  logic       r_cancel, r_rdy, r_e5, r_e1, r_ocupado, r_listo, r_err, w_err, w_acepta;
  function automatic state_t elige(input logic [3:0] p);
    elige = p >= 4'd5 ? PIDE5 : p != 4'd0 ? PIDE1 : FIN;
  endfunction
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1111110;
      4'd1: seg7 = 7'b0110000;
      4'd2: seg7 = 7'b1101101;
      4'd3: seg7 = 7'b1111001;
      4'd4: seg7 = 7'b0110011;
      4'd5: seg7 = 7'b1011011;
      4'd6: seg7 = 7'b1011111;
      4'd7: seg7 = 7'b1110000;
      4'd8: seg7 = 7'b1111111;
      4'd9: seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction
  // r_rdy holds off starts on the first edge after reset release
  assign w_acepta = r_state == INACTIVO && r_rdy && (iniciar || cancelar);
  assign w_err    = !r_cancel && r_saldo < r_precio;
  assign w_carga  = (r_cancel || w_err) ? r_saldo : r_saldo - r_precio;
  always_comb begin
    w_next = r_state;
    w_pend = r_pend;
    case (r_state)
      INACTIVO:   w_next = w_acepta ? CARGA : INACTIVO;
      CARGA: begin
        w_pend = w_carga;
        w_next = elige(w_carga);
      end
      PIDE5: begin
        w_pend = ack_moneda ? r_pend - 4'd5 : r_pend;
        w_next = ack_moneda ? ESPERA_ACK : PIDE5;
      end
      PIDE1: begin
        w_pend = ack_moneda ? r_pend - 4'd1 : r_pend;
        w_next = ack_moneda ? ESPERA_ACK : PIDE1;
      end
      ESPERA_ACK: w_next = ack_moneda ? ESPERA_ACK : elige(r_pend);
      FIN:        w_next = INACTIVO;
      default:    w_next = INACTIVO;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INACTIVO;
      r_pend    <= 4'd0;
      r_saldo   <= 4'd0;
      r_precio  <= 4'd0;
      r_cancel  <= 1'b0;
      r_rdy     <= 1'b0;
      r_e5      <= 1'b0;
      r_e1      <= 1'b0;
      r_ocupado <= 1'b0;
      r_listo   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pend    <= w_pend;
      r_rdy     <= 1'b1;
      r_e5      <= w_next == PIDE5;
      r_e1      <= w_next == PIDE1;
      r_ocupado <= w_next != INACTIVO;
      r_listo   <= r_state == FIN;
      if (w_acepta) begin
        r_saldo  <= saldo;
        r_precio <= precio;
        r_cancel <= cancelar;
      end
      if (r_state == CARGA) r_err <= w_err;
    end
  end
  assign w_unid      = r_pend >= 4'd10 ? r_pend - 4'd10 : r_pend;
  assign expulsar5   = r_e5;
  assign expulsar1   = r_e1;
  assign ocupado     = r_ocupado;
  assign listo       = r_listo;
  assign error_saldo = r_err;
  assign pendiente   = r_pend;
  assign segm1       = seg7(w_unid);
  assign segm2       = seg7({3'b000, r_pend >= 4'd10});
endmodule

// File: tb/tb_dispensador_cambio.sv
// tb_dispensador_cambio: directed scoreboard bench; expected coin sequences are queued at start and popped per request.
module tb_dispensador_cambio;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] saldo = 4'd0, precio = 4'd0;
  logic       iniciar = 1'b0, cancelar = 1'b0, ack_moneda = 1'b0;
  logic       expulsar5, expulsar1, ocupado, listo, error_saldo;
  logic [3:0] pendiente;
  logic [6:0] segm1, segm2;
  int         n_assert = 0, n_fail = 0, cyc, q[$];
  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  dispensador_cambio dut (
    .clk(clk), .rst_n(rst_n), .saldo(saldo), .precio(precio), .iniciar(iniciar),
    .cancelar(cancelar), .ack_moneda(ack_moneda), .expulsar5(expulsar5), .expulsar1(expulsar1),
    .ocupado(ocupado), .listo(listo), .error_saldo(error_saldo), .pendiente(pendiente),
    .segm1(segm1), .segm2(segm2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic chk_reset();
    chk("rst_e5", expulsar5, 0);
    chk("rst_e1", expulsar1, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_listo", listo, 0);
    chk("rst_err", error_saldo, 0);
    chk("rst_pend", pendiente, 0);
    chk("rst_segm1", segm1, 7'b1111110);
    chk("rst_segm2", segm2, 7'b1111110);
  endtask
  task automatic txn(input logic [3:0] s, input logic [3:0] p, input logic ini, input logic can,
                     input int hold, input logic mid, output int cycles);
    logic err;
    int   ch, t, rem, coin;
    bit   done;
    err = ini && !can && s < p;
    ch  = (can || s < p) ? int'(s) : int'(s) - int'(p);
    t = ch;
    while (t >= 5) begin q.push_back(5); t -= 5; end
    while (t > 0) begin q.push_back(1); t -= 1; end
    rem = ch;
    @(negedge clk);
    saldo = s; precio = p; iniciar = ini; cancelar = can;
    @(negedge clk);
    iniciar = 0; cancelar = 0;
    chk("ocupado_carga", ocupado, 1);
    @(negedge clk);
    chk("pend_load", pendiente, 16'(ch));
    chk("err_load", error_saldo, err);
    chk("segm1_load", segm1, seg_tab[ch % 10]);
    chk("segm2_load", segm2, seg_tab[ch / 10]);
    cycles = 0;
    done = 0;
    while (!done && cycles < 300) begin
      @(negedge clk);
      cycles++;
      chk("req_exclusive", expulsar5 & expulsar1, 0);
      if (listo) done = 1;
      else if (expulsar5 || expulsar1) begin
        coin = expulsar5 ? 5 : 1;
        if (q.size() == 0) chk("extra_coin", 16'(coin), 0);
        else chk("coin", 16'(coin), 16'(q.pop_front()));
        chk("pend_pre_ack", pendiente, 16'(rem));
        rem -= coin;
        ack_moneda = 1; iniciar = mid;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          cycles++;
          chk("req_low_ack", {expulsar5, expulsar1}, 0);
          chk("pend_post_ack", pendiente, 16'(rem));
        end
        ack_moneda = 0; iniciar = 0;
      end
    end
    chk("listo_seen", done, 1);
    chk("coins_left", 16'(q.size()), 0);
    chk("pend_end", pendiente, 0);
    chk("err_end", error_saldo, err);
    @(negedge clk);
    chk("listo_pulse", listo, 0);
    q.delete();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    // start held from release: first edge must not accept, second must
    rst_n = 1; iniciar = 1;
    @(negedge clk);
    chk("no_accept_edge1", ocupado, 0);
    @(negedge clk);
    chk("accept_edge2", ocupado, 1);
    iniciar = 0;
    repeat (4) @(negedge clk);
    chk("first_done", ocupado, 0);
    txn(4'd13, 4'd7, 1, 0, 1, 0, cyc);
    txn(4'd4, 4'd7, 1, 0, 1, 0, cyc);
    txn(4'd7, 4'd7, 1, 0, 1, 0, cyc);
    chk("zero_change_latency", 16'(cyc), 1);
    txn(4'd10, 4'd3, 1, 1, 2, 1, cyc);
    txn(4'd13, 4'd2, 1, 0, 5, 0, cyc);
    txn(4'd15, 4'd0, 1, 0, 1, 0, cyc);
    ack_moneda = 1;
    repeat (3) @(negedge clk);
    chk("idle_ack_ocupado", ocupado, 0);
    chk("idle_ack_pend", pendiente, 0);
    ack_moneda = 0;
    saldo = 4'd10; precio = 4'd0; iniciar = 1;
    @(negedge clk);
    iniciar = 0;
    cyc = 0;
    while (!expulsar5 && cyc < 10) begin @(negedge clk); cyc++; end
    chk("e5_before_reset", expulsar5, 1);
    #2 rst_n = 0;
    #1 chk_reset();
    @(negedge clk);
    chk_reset();
    rst_n = 1;
    txn(4'd9, 4'd1, 1, 0, 1, 0, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dispensador_cambio.md
DISPENSADOR_CAMBIO -- requirements
Module: dispensador_cambio

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 saldo  input  4  accumulated balance in units; sampled only on an accepted start.
REQ-005 precio  input  4  product price in units; sampled only on an accepted start.
REQ-006 iniciar  input  1  start request: pay change of saldo minus precio.
REQ-007 cancelar  input  1  start request: refund the whole saldo.
REQ-008 ack_moneda  input  1  coin ejector acknowledge, one coin physically released.
REQ-009 expulsar5  output  1  request to eject one 5-unit coin.
REQ-010 expulsar1  output  1  request to eject one 1-unit coin.
REQ-011 ocupado  output  1  high while a payout is in progress.
REQ-012 listo  output  1  one-cycle pulse when a payout completes.
REQ-013 error_saldo  output  1  last start had saldo < precio; held until the next accepted start.
REQ-014 pendiente  output  4  change still to be paid.
REQ-015 segm1, segm2  output  7  units and tens digits of pendiente, segments abcdefg, active-high.

Function
REQ-016 The FSM SHALL have the states INACTIVO, CARGA, PIDE5, PIDE1, ESPERA_ACK and FIN.
REQ-017 INACTIVO SHALL move to CARGA on iniciar or cancelar; if both are high, cancelar SHALL win.
REQ-018 CARGA SHALL load pendiente with saldo-precio if iniciar and saldo>=precio, with saldo if cancelar, and with saldo plus error_saldo=1 if iniciar and saldo<precio.
REQ-019 CARGA SHALL take exactly 1 cycle, then go to PIDE5 if pendiente>=5, to PIDE1 if 0<pendiente<5, and to FIN if pendiente=0.
REQ-020 PIDE5 and PIDE1 SHALL assert expulsar5 or expulsar1 respectively and hold it until ack_moneda is sampled high.
REQ-021 On that acknowledge edge, pendiente SHALL decrement by 5 or 1, the request SHALL drop, and the state SHALL become ESPERA_ACK.
REQ-022 ESPERA_ACK SHALL wait for ack_moneda low, hold both requests low for at least 1 cycle, then choose the next state by the rule in REQ-019.
REQ-023 Coin selection SHALL be greedy (5 first), and expulsar5 and expulsar1 SHALL never be high together.
REQ-024 FIN SHALL pulse listo for 1 cycle, then return to INACTIVO.
REQ-025 ocupado SHALL be high in every state except INACTIVO.
REQ-026 iniciar and cancelar SHALL be ignored while ocupado=1.
REQ-027 ack_moneda SHALL be ignored in INACTIVO, CARGA and FIN.
REQ-028 Subtraction SHALL be unsigned 4-bit, pendiente SHALL never wrap below 0, and the maximum payout SHALL be 15.
REQ-029 segm1 SHALL show pendiente mod 10 and segm2 SHALL show pendiente div 10 (0 or 1).
REQ-030 The segment codes SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-031 All outputs other than segm1 and segm2 SHALL be registered.

Reset
REQ-032 When rst_n is low, the block SHALL immediately force state=INACTIVO, pendiente=0, expulsar5=0, expulsar1=0, ocupado=0, listo=0 and error_saldo=0.
REQ-033 At reset, segm1 and segm2 SHALL both show 1111110.
REQ-034 Reset asserted mid-payout SHALL abandon the payout; the remaining change SHALL be lost and no request SHALL remain asserted.
REQ-035 After rst_n deasserts, the first accepted start SHALL be no earlier than the second rising edge.

Verification
REQ-036 saldo=13, precio=7, iniciar pulse -> pendiente=6; then expulsar5 with ack; then expulsar1 with ack; then pendiente=0 and listo pulses once; total 2 coins.
REQ-037 saldo=4, precio=7, iniciar -> error_saldo=1; four expulsar1 handshakes refund 4; then listo.
REQ-038 saldo=7, precio=7 -> no coin requests; listo is asserted 2 cycles after iniciar is accepted.
REQ-039 cancelar and iniciar together with saldo=10 -> two expulsar5 coins; iniciar is pulsed mid-payout and is ignored.
REQ-040 ack_moneda held high for 5 cycles during PIDE5 -> exactly one decrement; the next request is not raised until ack_moneda is low.
REQ-041 rst_n pulled low while expulsar5 is high -> all outputs reach their reset values without waiting for a clock edge; the next iniciar runs normally.
